// File: rtl/mc_exec_pkg.sv
// Shared encodings for the multicycle execute stage: ALU op codes, operand-B selects, FSM states.
package mc_exec_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_STEP = 2'b10;
  localparam logic [1:0] SRCB_ZERO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MULT
  } state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/mc_exec_unit_mul_seq.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle, XLEN cycles, 2*XLEN-bit product.
module mc_mul_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  logic [XLEN-1:0]   a_q;
  logic [2*XLEN-1:0] p_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic              done_q;

  // Upper half accumulates the multiplicand; lower half holds the unconsumed multiplier bits.
  function automatic logic [2*XLEN-1:0] step(input logic [XLEN-1:0] mcand,
                                             input logic [2*XLEN-1:0] p);
    logic [XLEN:0] sum;
    sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, mcand} : '0);
    return {sum, p[XLEN-1:1]};
  endfunction

  // The first step is folded into the load edge so the product lands XLEN-1 edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      p_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start && !busy_q) begin
        a_q    <= a;
        p_q    <= step(a, {{XLEN{1'b0}}, b});
        cnt_q  <= CW'(XLEN - 1);
        busy_q <= 1'b1;
      end else if (busy_q) begin
        p_q   <= step(a_q, p_q);
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = p_q;

endmodule

// File: rtl/mc_exec_unit.sv
// Multicycle execute stage: operand-B select, single-cycle ALU and sequenced multiplier behind
// a start/busy/done handshake with registered result, zero and illegal flags.
module mc_exec_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CONST_STEP = 4,
  parameter int unsigned MUL_EN     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [1:0]      src_b_sel,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm_ext,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  import mc_exec_pkg::*;

  localparam int unsigned SHW    = $clog2(XLEN);
  localparam bit          MUL_ON = (MUL_EN != 0);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, b_q, result_q, result_d;
  logic [3:0]        op_q;
  logic              zero_q, zero_d, illegal_q, illegal_d, done_q, done_d;
  logic [XLEN-1:0]   src_b, alu_res;
  logic              alu_ill, accept, mul_req, mul_busy, mul_done;
  logic [2*XLEN-1:0] mul_prod;

  always_comb begin
    unique case (src_b_sel)
      SRCB_RS2:  src_b = rs2_data;
      SRCB_IMM:  src_b = imm_ext;
      SRCB_STEP: src_b = XLEN'(CONST_STEP);
      default:   src_b = '0;
    endcase
  end

  // busy stays high through the done cycle, so a new start is taken only the cycle after.
  assign busy    = (state_q != ST_IDLE) || done_q || mul_busy;
  assign accept  = start && !busy;
  assign mul_req = MUL_ON && is_mul_op(op);

  mc_mul_seq #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .rst_n   (reset),
    .start   (accept && mul_req),
    .a       (rs1_data),
    .b       (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
      OP_SLL:  alu_res = a_q << b_q[SHW-1:0];
      OP_SRL:  alu_res = a_q >> b_q[SHW-1:0];
      OP_SRA:  alu_res = $signed(a_q) >>> b_q[SHW-1:0];
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = mul_req ? ST_MULT : ST_EXEC;
      end
      ST_EXEC: begin
        result_d  = alu_res;
        zero_d    = (alu_res == '0);
        illegal_d = alu_ill;
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_MULT: begin
        if (mul_done) begin
          result_d  = (op_q == OP_MULHU) ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];
          zero_d    = (result_d == '0);
          illegal_d = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      done_q    <= done_d;
      if (accept) begin
        a_q  <= rs1_data;
        b_q  <= src_b;
        op_q <= op;
      end
    end
  end

  assign done    = done_q;
  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_mc_exec_unit.sv
// Scoreboard bench for mc_exec_unit: expected results queued at issue, compared on each done pulse.
module tb_mc_exec_unit;

  import mc_exec_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            reset;
  logic            start;
  logic [3:0]      op;
  logic [1:0]      src_b_sel;
  logic [XLEN-1:0] rs1_data, rs2_data, imm_ext;
  logic            busy, done, zero, illegal;
  logic [XLEN-1:0] result;

  typedef struct {
    logic [XLEN-1:0] res;
    logic            z;
    logic            ill;
    int unsigned     cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;

  mc_exec_unit #(.XLEN(XLEN), .CONST_STEP(4), .MUL_EN(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .src_b_sel (src_b_sel),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .imm_ext   (imm_ext),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [XLEN:0] ref_exec(input logic [3:0] o, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      4'd0:    return {1'b0, a + b};
      4'd1:    return {1'b0, a - b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd5:    return {1'b0, 32'(($signed(a) < $signed(b)) ? 1 : 0)};
      4'd6:    return {1'b0, 32'((a < b) ? 1 : 0)};
      4'd7:    return {1'b0, a << b[4:0]};
      4'd8:    return {1'b0, a >> b[4:0]};
      4'd9:    return {1'b0, 32'($signed(a) >>> b[4:0])};
      4'd10:   return {1'b0, p[31:0]};
      4'd11:   return {1'b0, p[63:32]};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic issue(input logic [3:0] o, input logic [1:0] sel, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b2, input logic [XLEN-1:0] imm, input bit accepted);
    logic [XLEN-1:0] bsel;
    logic [XLEN:0]   r;
    exp_t            e;
    @(negedge clk);
    op = o; src_b_sel = sel; rs1_data = a; rs2_data = b2; imm_ext = imm;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom; imm_ext = $urandom; op = 4'($urandom_range(0, 15));
    if (accepted) begin
      case (sel)
        2'b00:   bsel = b2;
        2'b01:   bsel = imm;
        2'b10:   bsel = 32'd4;
        default: bsel = 32'd0;
      endcase
      r     = ref_exec(o, a, bsel);
      e.res = r[XLEN-1:0];
      e.ill = r[XLEN];
      e.z   = (r[XLEN-1:0] == 0);
      e.cyc = cyc + ((o == 4'd10 || o == 4'd11) ? XLEN : 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    if (!done) begin
      check_eq("done_timeout", 0, 1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("result", result, e.res);
        check_eq("zero", zero, e.z);
        check_eq("illegal", illegal, e.ill);
        check_eq("latency", cyc, e.cyc);
        check_eq("busy_at_done", busy, 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; op = '0; src_b_sel = '0;
    rs1_data = '0; rs2_data = '0; imm_ext = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_zero", zero, 1);
    check_eq("rst_illegal", illegal, 0);
    reset = 1'b1;

    issue(OP_ADD, SRCB_IMM, 32'd30, 32'd0, 32'd15, 1);  wait_done();
    issue(OP_SUB, SRCB_RS2, 32'd30, 32'd30, 32'd0, 1);  wait_done();
    issue(OP_ADD, SRCB_STEP, 32'd100, 32'd7, 32'd9, 1); wait_done();
    issue(OP_AND, SRCB_ZERO, 32'hFFFF_FFFF, 32'h5, 32'h6, 1); wait_done();
    issue(OP_SLT, SRCB_RS2, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);  wait_done();
    issue(OP_SLTU, SRCB_RS2, 32'hFFFF_FFFF, 32'd1, 32'd0, 1); wait_done();
    issue(OP_SRA, SRCB_RS2, 32'h8000_0000, 32'd4, 32'd0, 1);  wait_done();
    issue(OP_SLL, SRCB_RS2, 32'h0000_0001, 32'd31, 32'd0, 1); wait_done();
    issue(OP_SRL, SRCB_IMM, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1); wait_done();

    issue(OP_MUL, SRCB_RS2, 32'd7, 32'd6, 32'd0, 1);
    check_eq("busy_in_mul", busy, 1);
    wait_done();
    issue(OP_MULHU, SRCB_RS2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1); wait_done();

    issue(OP_MUL, SRCB_IMM, 32'd123456, 32'd0, 32'd789, 1);
    repeat (3) @(negedge clk);
    issue(OP_ADD, SRCB_RS2, 32'd1, 32'd2, 32'd0, 0);
    wait_done();

    issue(4'd13, SRCB_RS2, 32'd5, 32'd5, 32'd0, 1); wait_done();
    issue(4'd15, SRCB_IMM, 32'd9, 32'd0, 32'd3, 1); wait_done();

    for (int i = 0; i < 12; i++) begin
      issue(4'($urandom_range(0, 11)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1);
      wait_done();
    end

    issue(OP_ADD, SRCB_RS2, 32'd5, 32'd5, 32'd0, 1); wait_done();
    issue(OP_MUL, SRCB_RS2, 32'd11, 32'd13, 32'd0, 1);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_result", result, 0);
    check_eq("abort_zero", zero, 1);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("abort_idle", busy, 0);

    issue(4'd13, SRCB_RS2, 32'd1, 32'd1, 32'd0, 1); wait_done();
    issue(OP_XOR, SRCB_RS2, 32'hA5A5_0000, 32'h0000_5A5A, 32'd0, 1); wait_done();

    repeat (3) @(negedge clk);
    check_eq("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
